// File: rtl/m_stage_pkg.sv
// rtl/m_stage_pkg.sv - memory-op opcodes, exception codes, address map and E/M register layout
package m_stage_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  localparam logic [31:0] DM_LO  = 32'h0000_0000;
  localparam logic [31:0] DM_HI  = 32'h0000_2FFF;
  localparam logic [31:0] TC0_LO = 32'h0000_7F00;
  localparam logic [31:0] TC1_LO = 32'h0000_7F10;
  localparam logic [31:0] IG_LO  = 32'h0000_7F20;

  // Timers expose three words (last one is the read-only Count); IG exposes one word.
  localparam logic [31:0] TC_SPAN      = 32'h0000_000B;
  localparam logic [31:0] IG_SPAN      = 32'h0000_0003;
  localparam logic [31:0] TC_COUNT_OFS = 32'h0000_0008;

  typedef enum logic [3:0] {
    MOP_NONE,
    MOP_LW,
    MOP_LH,
    MOP_LHU,
    MOP_LB,
    MOP_LBU,
    MOP_SW,
    MOP_SH,
    MOP_SB
  } mem_op_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] wdata;
    logic [31:0] reg_data;
    logic [4:0]  reg_addr;
    logic        reg_write;
    logic        ov;
    logic [4:0]  exc;
    logic        bd;
  } e2m_t;

  function automatic mem_op_e decode_mem_op(input logic [5:0] op);
    mem_op_e m;
    case (op)
      OP_LW:   m = MOP_LW;
      OP_LH:   m = MOP_LH;
      OP_LHU:  m = MOP_LHU;
      OP_LB:   m = MOP_LB;
      OP_LBU:  m = MOP_LBU;
      OP_SW:   m = MOP_SW;
      OP_SH:   m = MOP_SH;
      OP_SB:   m = MOP_SB;
      default: m = MOP_NONE;
    endcase
    return m;
  endfunction

  function automatic logic in_range(input logic [31:0] a, input logic [31:0] lo,
                                    input logic [31:0] hi);
    return (a >= lo) && (a <= hi);
  endfunction

endpackage

// File: rtl/m_stage_if.sv
// rtl/m_stage_if.sv - data bus between the M stage and DM / memory-mapped devices
interface m_stage_if;
  logic [31:0] m_data_addr;
  logic [31:0] m_data_wdata;
  logic [3:0]  m_data_byteen;
  logic [31:0] m_data_rdata;

  modport master (
    output m_data_addr,
    output m_data_wdata,
    output m_data_byteen,
    input  m_data_rdata
  );

  modport slave (
    input  m_data_addr,
    input  m_data_wdata,
    input  m_data_byteen,
    output m_data_rdata
  );
endinterface

// File: rtl/m_mem_ctrl.sv
// rtl/m_mem_ctrl.sv - memory-op decode, byte lanes, load extension and AdEL/AdES detection
module m_mem_ctrl
  import m_stage_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] rt,
  input  logic [31:0] rdata,
  input  logic [31:0] reg_data,
  input  logic        ov,
  input  logic        int_req,
  input  logic [4:0]  exc_in,
  output logic [3:0]  byteen,
  output logic [31:0] wdata,
  output logic [31:0] result,
  output logic [4:0]  exc_code
);

  mem_op_e     mop;
  logic        is_load;
  logic        is_store;
  logic        in_dm;
  logic        in_dev;
  logic        count_hit;
  logic        misaligned;
  logic        addr_err;
  logic [3:0]  be_raw;
  logic [15:0] half_v;
  logic [7:0]  byte_v;

  always_comb begin
    mop      = decode_mem_op(op);
    is_load  = (mop == MOP_LW) || (mop == MOP_LH) || (mop == MOP_LHU) ||
               (mop == MOP_LB) || (mop == MOP_LBU);
    is_store = (mop == MOP_SW) || (mop == MOP_SH) || (mop == MOP_SB);

    in_dm     = in_range(addr, DM_LO, DM_HI);
    in_dev    = in_range(addr, TC0_LO, TC0_LO + TC_SPAN) ||
                in_range(addr, TC1_LO, TC1_LO + TC_SPAN) ||
                in_range(addr, IG_LO, IG_LO + IG_SPAN);
    count_hit = (addr == TC0_LO + TC_COUNT_OFS) || (addr == TC1_LO + TC_COUNT_OFS);

    misaligned = 1'b0;
    be_raw     = 4'b0000;
    wdata      = rt;
    case (mop)
      MOP_LW: misaligned = (addr[1:0] != 2'b00);
      MOP_LH, MOP_LHU: misaligned = addr[0];
      MOP_SW: begin
        misaligned = (addr[1:0] != 2'b00);
        be_raw     = 4'b1111;
      end
      MOP_SH: begin
        misaligned = addr[0];
        be_raw     = addr[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{rt[15:0]}};
      end
      MOP_SB: begin
        be_raw = 4'b0001 << addr[1:0];
        wdata  = {4{rt[7:0]}};
      end
      default: ;
    endcase

    // Devices only accept whole-word access; the timer Count word is never writable.
    addr_err = misaligned || ov || !(in_dm || in_dev) ||
               (in_dev && (mop != MOP_LW) && (mop != MOP_SW)) ||
               ((mop == MOP_SW) && count_hit);

    if (exc_in != EXC_NONE)
      exc_code = exc_in;
    else if (is_load && addr_err)
      exc_code = EXC_ADEL;
    else if (is_store && addr_err)
      exc_code = EXC_ADES;
    else
      exc_code = EXC_NONE;

    byteen = (is_store && (exc_code == EXC_NONE) && !int_req) ? be_raw : 4'b0000;

    half_v = addr[1] ? rdata[31:16] : rdata[15:0];
    case (addr[1:0])
      2'd0:    byte_v = rdata[7:0];
      2'd1:    byte_v = rdata[15:8];
      2'd2:    byte_v = rdata[23:16];
      default: byte_v = rdata[31:24];
    endcase

    case (mop)
      MOP_LW:  result = rdata;
      MOP_LH:  result = {{16{half_v[15]}}, half_v};
      MOP_LHU: result = {16'h0000, half_v};
      MOP_LB:  result = {{24{byte_v[7]}}, byte_v};
      MOP_LBU: result = {24'h000000, byte_v};
      default: result = reg_data;
    endcase
  end

endmodule

// File: rtl/m_stage.sv
// rtl/m_stage.sv - MIPS memory stage: E/M pipeline register plus data-bus access
module m_stage
  import m_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        IntReq,
  input  logic [31:0] E_Instr,
  input  logic [31:0] E_PC,
  input  logic [31:0] E_ALUResult,
  input  logic [31:0] E_WriteData,
  input  logic [31:0] E_RegData,
  input  logic [4:0]  E_RegAddr,
  input  logic        E_RegWrite,
  input  logic        E_Ov,
  input  logic [4:0]  E_ExcCode,
  input  logic        E_BD,
  m_stage_if.master   bus,
  output logic [31:0] M_Instr,
  output logic [31:0] M_PC,
  output logic [31:0] M_RegData,
  output logic [31:0] M_FwdData,
  output logic [4:0]  M_RegAddr,
  output logic        M_RegWrite,
  output logic [4:0]  M_ExcCode,
  output logic        M_BD
);

  e2m_t e2m_d;
  e2m_t e2m_q;

  // IntReq squashes the incoming instruction into a bubble (sll $0,$0,0 at PC 0).
  always_comb begin
    e2m_d = '0;
    if (!IntReq) begin
      e2m_d.instr     = E_Instr;
      e2m_d.pc        = E_PC;
      e2m_d.alu       = E_ALUResult;
      e2m_d.wdata     = E_WriteData;
      e2m_d.reg_data  = E_RegData;
      e2m_d.reg_addr  = E_RegAddr;
      e2m_d.reg_write = E_RegWrite;
      e2m_d.ov        = E_Ov;
      e2m_d.exc       = E_ExcCode;
      e2m_d.bd        = E_BD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      e2m_q <= '0;
    else
      e2m_q <= e2m_d;
  end

  m_mem_ctrl u_mem_ctrl (
    .op       (e2m_q.instr[31:26]),
    .addr     (e2m_q.alu),
    .rt       (e2m_q.wdata),
    .rdata    (bus.m_data_rdata),
    .reg_data (e2m_q.reg_data),
    .ov       (e2m_q.ov),
    .int_req  (IntReq),
    .exc_in   (e2m_q.exc),
    .byteen   (bus.m_data_byteen),
    .wdata    (bus.m_data_wdata),
    .result   (M_RegData),
    .exc_code (M_ExcCode)
  );

  assign bus.m_data_addr = e2m_q.alu;

  assign M_Instr    = e2m_q.instr;
  assign M_PC       = e2m_q.pc;
  assign M_FwdData  = e2m_q.reg_data;
  assign M_RegAddr  = e2m_q.reg_addr;
  assign M_RegWrite = e2m_q.reg_write && (M_ExcCode == EXC_NONE);
  assign M_BD       = e2m_q.bd;

endmodule

// File: tb/tb_m_stage.sv
// tb/tb_m_stage.sv - directed self-checking bench for m_stage
module tb_m_stage;
  import m_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        IntReq;
  logic [31:0] E_Instr, E_PC, E_ALUResult, E_WriteData, E_RegData;
  logic [4:0]  E_RegAddr, E_ExcCode;
  logic        E_RegWrite, E_Ov, E_BD;
  logic [31:0] M_Instr, M_PC, M_RegData, M_FwdData;
  logic [4:0]  M_RegAddr, M_ExcCode;
  logic        M_RegWrite, M_BD;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_pc;
  logic [31:0] mem [0:3071];

  m_stage_if bus ();

  m_stage dut (
    .clk(clk), .reset(reset), .IntReq(IntReq),
    .E_Instr(E_Instr), .E_PC(E_PC), .E_ALUResult(E_ALUResult),
    .E_WriteData(E_WriteData), .E_RegData(E_RegData), .E_RegAddr(E_RegAddr),
    .E_RegWrite(E_RegWrite), .E_Ov(E_Ov), .E_ExcCode(E_ExcCode), .E_BD(E_BD),
    .bus(bus.master),
    .M_Instr(M_Instr), .M_PC(M_PC), .M_RegData(M_RegData), .M_FwdData(M_FwdData),
    .M_RegAddr(M_RegAddr), .M_RegWrite(M_RegWrite), .M_ExcCode(M_ExcCode), .M_BD(M_BD)
  );

  always #5 clk = ~clk;

  // Data memory model: combinational read, byte-lane write at the clock edge.
  always_comb begin
    bus.m_data_rdata = 32'h0;
    if (bus.m_data_addr <= 32'h0000_2FFF) bus.m_data_rdata = mem[bus.m_data_addr[13:2]];
  end

  always @(posedge clk) begin
    if (bus.m_data_addr <= 32'h0000_2FFF) begin
      for (int b = 0; b < 4; b++)
        if (bus.m_data_byteen[b]) mem[bus.m_data_addr[13:2]][8*b +: 8] <= bus.m_data_wdata[8*b +: 8];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_e(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rt,
                       input logic rw, input logic ov, input logic [4:0] exc);
    E_Instr     = {op, 5'd4, 5'd9, 16'h0000};
    E_PC        = E_PC + 32'd4;
    E_ALUResult = addr;
    E_WriteData = rt;
    E_RegData   = 32'h0000_D00D;
    E_RegAddr   = 5'd9;
    E_RegWrite  = rw;
    E_Ov        = ov;
    E_ExcCode   = exc;
    E_BD        = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    IntReq = 1'b0;
    E_PC = 32'h0000_3000;
    set_e(OP_SW, 32'h100, 32'hFFFF_FFFF, 1'b1, 1'b0, 5'd0);
    E_BD = 1'b1;
    step();
    n_cmp++; if (M_Instr !== 32'h0) begin n_err++; $display("FAIL reset_instr got %h want 0", M_Instr); end
    n_cmp++; if (M_PC !== 32'h0) begin n_err++; $display("FAIL reset_pc got %h want 0", M_PC); end
    n_cmp++; if (bus.m_data_byteen !== 4'h0) begin n_err++; $display("FAIL reset_byteen got %b want 0000", bus.m_data_byteen); end
    n_cmp++; if ({M_RegWrite, M_BD, M_ExcCode, M_RegAddr} !== 12'h0) begin n_err++; $display("FAIL reset_ctrl got %b%b %h %h want 0", M_RegWrite, M_BD, M_ExcCode, M_RegAddr); end
    reset = 1'b0;
  endtask

  task automatic test_sw_lw();
    set_e(OP_SW, 32'h100, 32'h1234_5678, 1'b0, 1'b0, 5'd0);
    exp_pc = E_PC;
    step();
    n_cmp++; if (bus.m_data_byteen !== 4'b1111) begin n_err++; $display("FAIL sw_byteen got %b want 1111", bus.m_data_byteen); end
    n_cmp++; if (bus.m_data_wdata !== 32'h1234_5678) begin n_err++; $display("FAIL sw_wdata got %h want 12345678", bus.m_data_wdata); end
    n_cmp++; if (M_PC !== exp_pc || bus.m_data_addr !== 32'h100) begin n_err++; $display("FAIL sw_pc_addr got %h/%h want %h/00000100", M_PC, bus.m_data_addr, exp_pc); end
    set_e(OP_LW, 32'h100, 32'h0, 1'b1, 1'b0, 5'd0);
    step();
    n_cmp++; if (M_RegData !== 32'h1234_5678) begin n_err++; $display("FAIL lw_data got %h want 12345678", M_RegData); end
    n_cmp++; if (M_FwdData !== 32'h0000_D00D || M_RegWrite !== 1'b1 || M_ExcCode !== 5'd0) begin n_err++; $display("FAIL lw_ctrl got %h %b %0d want 0000d00d 1 0", M_FwdData, M_RegWrite, M_ExcCode); end
    n_cmp++; if (bus.m_data_byteen !== 4'b0000) begin n_err++; $display("FAIL lw_byteen got %b want 0000", bus.m_data_byteen); end
  endtask

  task automatic test_sub_word();
    set_e(OP_SB, 32'h103, 32'h1111_11AB, 1'b0, 1'b0, 5'd0);
    step();
    n_cmp++; if (bus.m_data_byteen !== 4'b1000) begin n_err++; $display("FAIL sb_byteen got %b want 1000", bus.m_data_byteen); end
    n_cmp++; if (bus.m_data_wdata !== 32'hABAB_ABAB) begin n_err++; $display("FAIL sb_wdata got %h want abababab", bus.m_data_wdata); end
    set_e(OP_LB, 32'h103, 32'h0, 1'b1, 1'b0, 5'd0);
    step();
    n_cmp++; if (M_RegData !== 32'hFFFF_FFAB) begin n_err++; $display("FAIL lb_data got %h want ffffffab", M_RegData); end
    set_e(OP_LBU, 32'h103, 32'h0, 1'b1, 1'b0, 5'd0);
    step();
    n_cmp++; if (M_RegData !== 32'h0000_00AB) begin n_err++; $display("FAIL lbu_data got %h want 000000ab", M_RegData); end
    set_e(OP_LH, 32'h102, 32'h0, 1'b1, 1'b0, 5'd0);
    step();
    n_cmp++; if (M_RegData !== 32'hFFFF_AB34) begin n_err++; $display("FAIL lh_data got %h want ffffab34", M_RegData); end
    set_e(OP_LHU, 32'h100, 32'h0, 1'b1, 1'b0, 5'd0);
    step();
    n_cmp++; if (M_RegData !== 32'h0000_5678) begin n_err++; $display("FAIL lhu_data got %h want 00005678", M_RegData); end
    set_e(OP_SH, 32'h102, 32'h0000_BEEF, 1'b0, 1'b0, 5'd0);
    step();
    n_cmp++; if (bus.m_data_byteen !== 4'b1100 || bus.m_data_wdata !== 32'hBEEF_BEEF) begin n_err++; $display("FAIL sh_lanes got %b %h want 1100 beefbeef", bus.m_data_byteen, bus.m_data_wdata); end
  endtask

  task automatic test_addr_exc();
    set_e(OP_LW, 32'h102, 32'h0, 1'b1, 1'b0, 5'd0);
    step();
    n_cmp++; if (M_ExcCode !== 5'd4 || M_RegWrite !== 1'b0) begin n_err++; $display("FAIL lw_misaligned got exc %0d rw %b want 4 0", M_ExcCode, M_RegWrite); end
    set_e(OP_SH, 32'h101, 32'h55, 1'b0, 1'b0, 5'd0);
    step();
    n_cmp++; if (M_ExcCode !== 5'd5 || bus.m_data_byteen !== 4'b0000) begin n_err++; $display("FAIL sh_misaligned got exc %0d be %b want 5 0000", M_ExcCode, bus.m_data_byteen); end
    set_e(OP_SW, 32'h7F08, 32'h55, 1'b0, 1'b0, 5'd0);
    step();
    n_cmp++; if (M_ExcCode !== 5'd5 || bus.m_data_byteen !== 4'b0000) begin n_err++; $display("FAIL sw_count got exc %0d be %b want 5 0000", M_ExcCode, bus.m_data_byteen); end
    set_e(OP_SW, 32'h7F18, 32'h55, 1'b0, 1'b0, 5'd0);
    step();
    n_cmp++; if (M_ExcCode !== 5'd5) begin n_err++; $display("FAIL sw_count1 got exc %0d want 5", M_ExcCode); end
    set_e(OP_LW, 32'h3000, 32'h0, 1'b1, 1'b0, 5'd0);
    step();
    n_cmp++; if (M_ExcCode !== 5'd4) begin n_err++; $display("FAIL lw_above_dm got exc %0d want 4", M_ExcCode); end
    set_e(OP_LW, 32'h2FFC, 32'h0, 1'b1, 1'b0, 5'd0);
    step();
    n_cmp++; if (M_ExcCode !== 5'd0 || M_RegWrite !== 1'b1) begin n_err++; $display("FAIL lw_dm_top got exc %0d rw %b want 0 1", M_ExcCode, M_RegWrite); end
    set_e(OP_SW, 32'h7F04, 32'h0000_0077, 1'b0, 1'b0, 5'd0);
    step();
    n_cmp++; if (M_ExcCode !== 5'd0 || bus.m_data_byteen !== 4'b1111) begin n_err++; $display("FAIL sw_tc0_preset got exc %0d be %b want 0 1111", M_ExcCode, bus.m_data_byteen); end
    set_e(OP_LB, 32'h7F20, 32'h0, 1'b1, 1'b0, 5'd0);
    step();
    n_cmp++; if (M_ExcCode !== 5'd4) begin n_err++; $display("FAIL lb_ig got exc %0d want 4", M_ExcCode); end
    set_e(OP_LW, 32'h7F24, 32'h0, 1'b1, 1'b0, 5'd0);
    step();
    n_cmp++; if (M_ExcCode !== 5'd4) begin n_err++; $display("FAIL lw_past_ig got exc %0d want 4", M_ExcCode); end
    set_e(OP_SW, 32'h100, 32'h55, 1'b0, 1'b1, 5'd0);
    step();
    n_cmp++; if (M_ExcCode !== 5'd5 || bus.m_data_byteen !== 4'b0000) begin n_err++; $display("FAIL sw_ov got exc %0d be %b want 5 0000", M_ExcCode, bus.m_data_byteen); end
  endtask

  task automatic test_intreq();
    set_e(OP_SW, 32'h200, 32'hCAFE_F00D, 1'b1, 1'b0, 5'd0);
    step();
    IntReq = 1'b1;
    #1;
    n_cmp++; if (bus.m_data_byteen !== 4'b0000) begin n_err++; $display("FAIL intreq_byteen got %b want 0000", bus.m_data_byteen); end
    set_e(OP_LW, 32'h100, 32'h0, 1'b1, 1'b0, 5'd0);
    step();
    IntReq = 1'b0;
    n_cmp++; if (M_Instr !== 32'h0 || M_PC !== 32'h0 || M_RegWrite !== 1'b0) begin n_err++; $display("FAIL intreq_flush got %h %h %b want 0 0 0", M_Instr, M_PC, M_RegWrite); end
    n_cmp++; if (mem[128] !== 32'h0) begin n_err++; $display("FAIL intreq_no_write got %h want 00000000", mem[128]); end
    set_e(OP_SH, 32'h101, 32'h55, 1'b0, 1'b0, 5'd0);
    step();
    IntReq = 1'b1;
    #1;
    n_cmp++; if (M_ExcCode !== 5'd5 || bus.m_data_byteen !== 4'b0000) begin n_err++; $display("FAIL intreq_exc got exc %0d be %b want 5 0000", M_ExcCode, bus.m_data_byteen); end
    step();
    IntReq = 1'b0;
  endtask

  task automatic test_passthrough();
    set_e(OP_SW, 32'h7F08, 32'h55, 1'b0, 1'b0, 5'd10);
    step();
    n_cmp++; if (M_ExcCode !== 5'd10 || bus.m_data_byteen !== 4'b0000) begin n_err++; $display("FAIL exc_passthrough got exc %0d be %b want 10 0000", M_ExcCode, bus.m_data_byteen); end
  endtask

  task automatic test_reset_mid();
    set_e(OP_LHU, 32'h100, 32'h0, 1'b1, 1'b0, 5'd0);
    step();
    n_cmp++; if (M_RegData !== 32'h0000_5678) begin n_err++; $display("FAIL lhu_stream got %h want 00005678", M_RegData); end
    reset = 1'b1;
    set_e(OP_LHU, 32'h104, 32'h0, 1'b1, 1'b0, 5'd0);
    step();
    reset = 1'b0;
    n_cmp++; if (M_Instr !== 32'h0 || M_RegData !== 32'h0 || bus.m_data_addr !== 32'h0 || M_RegWrite !== 1'b0 || M_ExcCode !== 5'd0) begin n_err++; $display("FAIL reset_mid got %h %h %h %b %0d want all 0", M_Instr, M_RegData, bus.m_data_addr, M_RegWrite, M_ExcCode); end
    set_e(OP_LHU, 32'h7F00, 32'h0, 1'b1, 1'b0, 5'd0);
    step();
    n_cmp++; if (M_ExcCode !== 5'd4 || M_RegWrite !== 1'b0) begin n_err++; $display("FAIL lhu_tc0 got exc %0d rw %b want 4 0", M_ExcCode, M_RegWrite); end
  endtask

  initial begin
    for (int i = 0; i < 3072; i++) mem[i] = 32'h0;
    test_reset();
    test_sw_lw();
    test_sub_word();
    test_addr_exc();
    test_intreq();
    test_passthrough();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
